// File: rtl/mean_window_feeder.sv
// Producer side of the 3x3 mean filter: buffers two lines and presents valid-region windows.
// Define WIN_TIMEOUT_EN to add a WAIT_DONE watchdog that sets a sticky err_o and skips the window.
module mean_window_feeder #(
    parameter int IMG_WIDTH      = 8,
    parameter int IMG_HEIGHT     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i_win,
    input  logic                  rst_i_win,
    input  logic [DATA_WIDTH-1:0] pix_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    output logic [DATA_WIDTH-1:0] win_o_0,
    output logic [DATA_WIDTH-1:0] win_o_1,
    output logic [DATA_WIDTH-1:0] win_o_2,
    output logic [DATA_WIDTH-1:0] win_o_3,
    output logic [DATA_WIDTH-1:0] win_o_4,
    output logic [DATA_WIDTH-1:0] win_o_5,
    output logic [DATA_WIDTH-1:0] win_o_6,
    output logic [DATA_WIDTH-1:0] win_o_7,
    output logic [DATA_WIDTH-1:0] win_o_8,
    output logic                  win_en_o,
    input  logic                  win_done_i,
    output logic                  frame_done_o,
    output logic                  err_o
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mean_window_feeder: IMG_WIDTH and IMG_HEIGHT must be >= 3, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {FILL, ISSUE, WAIT_DONE, GAP} state_t;

    state_t                 state;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   last_flag;
    logic [DATA_WIDTH-1:0]  lb_a     [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]  lb_b     [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]  left_col [3];
    logic [DATA_WIDTH-1:0]  mid_col  [3];
    logic [DATA_WIDTH-1:0]  new_col  [3];
    logic [DATA_WIDTH-1:0]  win_q    [9];
    logic                   xfer;
    logic                   at_last_col;
    logic                   at_last_row;
    logic                   win_ready;
    logic                   tmo_hit;
    logic                   wait_exit;

    assign xfer        = pix_valid_i && pix_ready_o;
    assign at_last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign at_last_row = (row == ROW_W'(IMG_HEIGHT - 1));
    assign win_ready   = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign wait_exit   = win_done_i || tmo_hit;

    assign new_col[0] = lb_a[col];
    assign new_col[1] = lb_b[col];
    assign new_col[2] = pix_i;

    assign win_o_0 = win_q[0];
    assign win_o_1 = win_q[1];
    assign win_o_2 = win_q[2];
    assign win_o_3 = win_q[3];
    assign win_o_4 = win_q[4];
    assign win_o_5 = win_q[5];
    assign win_o_6 = win_q[6];
    assign win_o_7 = win_q[7];
    assign win_o_8 = win_q[8];

    // Line buffers and the two trailing window columns are not reset; rows 0-1 refill them first.
    always_ff @(posedge clk_i_win) begin
        if (xfer) begin
            lb_a[col] <= lb_b[col];
            lb_b[col] <= pix_i;
            left_col  <= mid_col;
            mid_col   <= new_col;
        end
    end

`ifdef WIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i_win or posedge rst_i_win) begin
        if (rst_i_win) begin
            tmo_cnt <= '0;
            err_o   <= 1'b0;
        end else if (state != WAIT_DONE) begin
            tmo_cnt <= '0;
        end else begin
            if (!win_done_i && tmo_hit) begin
                err_o <= 1'b1;
            end
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    // The window is captured from the completing pixel's column on the same edge that enters ISSUE.
    always_ff @(posedge clk_i_win or posedge rst_i_win) begin
        if (rst_i_win) begin
            state        <= FILL;
            col          <= '0;
            row          <= '0;
            last_flag    <= 1'b0;
            pix_ready_o  <= 1'b0;
            win_en_o     <= 1'b0;
            frame_done_o <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                FILL: begin
                    pix_ready_o <= 1'b1;
                    if (xfer) begin
                        if (at_last_col) begin
                            col <= '0;
                            row <= at_last_row ? '0 : row + ROW_W'(1);
                            if (at_last_row) begin
                                last_flag <= 1'b1;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (win_ready) begin
                            state       <= ISSUE;
                            pix_ready_o <= 1'b0;
                            win_en_o    <= 1'b1;
                            win_q       <= '{left_col[0], mid_col[0], new_col[0],
                                             left_col[1], mid_col[1], new_col[1],
                                             left_col[2], mid_col[2], new_col[2]};
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (wait_exit) begin
                        state        <= GAP;
                        win_en_o     <= 1'b0;
                        frame_done_o <= last_flag;
                        last_flag    <= 1'b0;
                    end
                end
                GAP: begin
                    state       <= FILL;
                    pix_ready_o <= 1'b1;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mean_window_feeder.sv
// Randomized bench for mean_window_feeder: a frame-level reference model predicts every output
// each cycle, and literal window values pin the model on the first two sequential frames.
module tb_mean_window_feeder;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int DW  = 8;
    localparam int TMO = 8;

    logic          clk_i_win   = 1'b0;
    logic          rst_i_win   = 1'b0;
    logic [DW-1:0] pix_i       = '0;
    logic          pix_valid_i = 1'b0;
    logic          pix_ready_o;
    logic [DW-1:0] win_o_0, win_o_1, win_o_2, win_o_3, win_o_4, win_o_5, win_o_6, win_o_7, win_o_8;
    logic          win_en_o;
    logic          win_done_i  = 1'b0;
    logic          frame_done_o;
    logic          err_o;

    mean_window_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i_win(clk_i_win), .rst_i_win(rst_i_win),
        .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .win_o_0(win_o_0), .win_o_1(win_o_1), .win_o_2(win_o_2),
        .win_o_3(win_o_3), .win_o_4(win_o_4), .win_o_5(win_o_5),
        .win_o_6(win_o_6), .win_o_7(win_o_7), .win_o_8(win_o_8),
        .win_en_o(win_en_o), .win_done_i(win_done_i),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk_i_win = ~clk_i_win;

    logic [9*DW-1:0] dut_win;
    assign dut_win = {win_o_0, win_o_1, win_o_2, win_o_3, win_o_4, win_o_5, win_o_6, win_o_7, win_o_8};

    int checks = 0;
    int errors = 0;
    int stream[$];
    int next_seq = 0;
    int valid_pct = 100;
    int lat_min = 5;
    int lat_max = 5;
    int spur_pct = 0;
    int cyc = 0;
    int c10 = -1;
    int first_en_cyc = -1;
    int fd_count = 0;
    int wcnt = 0;
    int cur_lat = 5;
    bit cmp_on = 1'b0;
    bit prev_en = 1'b0;
    logic [9*DW-1:0] cap[$];

    typedef enum int {M_FILL, M_ISSUE, M_WAIT, M_GAP} mphase_t;
    mphase_t         m_phase = M_FILL;
    logic            m_ready = 1'b0;
    logic            m_en = 1'b0;
    logic            m_fd = 1'b0;
    logic            m_err = 1'b0;
    logic [9*DW-1:0] m_win = '0;
    bit              m_last = 1'b0;
    int              m_taken = 0;
    int              m_pos = 0;
    int              m_frames = 0;
    int              m_waited = 0;
    int              m_r, m_c;
    int              img[H][W];

    task automatic checkOutput(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int v0, input int v1, input int v2, input int v3,
                                               input int v4, input int v5, input int v6, input int v7,
                                               input int v8);
        return {DW'(v0), DW'(v1), DW'(v2), DW'(v3), DW'(v4), DW'(v5), DW'(v6), DW'(v7), DW'(v8)};
    endfunction

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_ready"}, pix_ready_o, 0);
        checkOutput({tag, "_en"}, win_en_o, 0);
        checkOutput({tag, "_fd"}, frame_done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
        checkOutput({tag, "_win"}, dut_win, 0);
    endtask

    task automatic pushFrame(input bit rnd);
        for (int k = 0; k < W * H; k++) begin
            if (rnd) begin
                stream.push_back(int'($urandom_range(255)));
            end else begin
                stream.push_back(next_seq);
                next_seq++;
            end
        end
    endtask

    task automatic applyStimulus(input bit rnd, input int vpct, input int lmin, input int lmax, input int spct);
        int start;
        valid_pct = vpct;
        lat_min   = lmin;
        lat_max   = lmax;
        spur_pct  = spct;
        start     = m_frames;
        pushFrame(rnd);
        for (int n = 0; n < 3000 && m_frames == start; n++) @(negedge clk_i_win);
        #1;
        checkOutput("frame_complete", m_frames - start, 1);
    endtask

    // Reference model: places each accepted pixel in the frame image and derives the protocol outputs.
    initial forever begin
        @(posedge clk_i_win or posedge rst_i_win);
        if (rst_i_win) begin
            m_phase = M_FILL; m_ready = 0; m_en = 0; m_fd = 0; m_err = 0; m_win = '0;
            m_last = 0; m_taken = 0; m_pos = 0; m_waited = 0;
        end else begin
            cyc++;
            m_fd = 1'b0;
            case (m_phase)
                M_FILL: begin
                    if (m_ready && pix_valid_i) begin
                        m_r = m_pos / W;
                        m_c = m_pos % W;
                        img[m_r][m_c] = int'(pix_i);
                        if (m_taken == 10 && c10 < 0) c10 = cyc;
                        m_taken++;
                        m_pos = (m_pos + 1) % (W * H);
                        if (m_r >= 2 && m_c >= 2) begin
                            for (int i = 0; i < 3; i++)
                                for (int j = 0; j < 3; j++)
                                    m_win[(8 - (i * 3 + j)) * DW +: DW] = DW'(img[m_r - 2 + i][m_c - 2 + j]);
                            if (m_pos == 0) m_last = 1;
                            m_phase = M_ISSUE;
                            m_en    = 1;
                            m_ready = 0;
                        end
                    end
                    if (m_phase == M_FILL) m_ready = 1;
                end
                M_ISSUE: begin
                    m_phase  = M_WAIT;
                    m_waited = 0;
                end
                M_WAIT: begin
                    m_waited++;
`ifdef WIN_TIMEOUT_EN
                    if (!win_done_i && m_waited == TMO) m_err = 1;
                    if (win_done_i || m_waited == TMO) begin
`else
                    if (win_done_i) begin
`endif
                        m_phase = M_GAP;
                        m_en    = 0;
                        m_fd    = m_last;
                        m_last  = 0;
                        if (m_fd) m_frames++;
                    end
                end
                default: begin
                    m_phase = M_FILL;
                    m_ready = 1;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk_i_win);
        if (m_taken < stream.size()) begin
            pix_i       = DW'(stream[m_taken]);
            pix_valid_i = (int'($urandom_range(99)) < valid_pct);
        end else begin
            pix_valid_i = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk_i_win);
        if (m_en) begin
            wcnt++;
            win_done_i = (wcnt >= cur_lat);
        end else begin
            wcnt       = 0;
            cur_lat    = int'($urandom_range(lat_max, lat_min));
            win_done_i = (int'($urandom_range(99)) < spur_pct);
        end
    end

    initial forever begin
        @(negedge clk_i_win);
        if (cmp_on) begin
            checkOutput("pix_ready", pix_ready_o, m_ready);
            checkOutput("win_en", win_en_o, m_en);
            checkOutput("frame_done", frame_done_o, m_fd);
            checkOutput("err", err_o, m_err);
            checkOutput("window", dut_win, m_win);
        end
        if (rst_i_win) begin
            prev_en = 1'b0;
        end else begin
            if (win_en_o && !prev_en) begin
                cap.push_back(dut_win);
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (frame_done_o) fd_count++;
            prev_en = win_en_o;
        end
    end

    initial begin
        #1 rst_i_win = 1'b1;
        #1 resetChecks("rst");
        cmp_on = 1'b1;
        @(negedge clk_i_win);
        @(negedge clk_i_win);
        rst_i_win = 1'b0;
        @(posedge clk_i_win);
        #1 checkOutput("ready_after_reset", pix_ready_o, 1);

        applyStimulus(1'b0, 100, 5, 5, 0);
        checkOutput("frameA_fd_count", fd_count, 1);
        checkOutput("frameA_windows", cap.size(), 4);
        checkOutput("first_en_latency", first_en_cyc, c10);
        checkOutput("win1_literal", cap[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        checkOutput("win2_literal", cap[1], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        checkOutput("centre1", cap[0][4*DW +: DW], 5);
        checkOutput("centre2", cap[1][4*DW +: DW], 6);
        checkOutput("centre3", cap[2][4*DW +: DW], 9);
        checkOutput("centre4", cap[3][4*DW +: DW], 10);

        applyStimulus(1'b0, 100, 5, 5, 0);
        checkOutput("frameB_fd_count", fd_count, 2);
        checkOutput("frameB_win1_literal", cap[4], pack9(16, 17, 18, 20, 21, 22, 24, 25, 26));

        for (int f = 0; f < 6; f++) begin
            applyStimulus(1'b1, int'($urandom_range(90, 30)), 2, 6, 25);
        end

        applyStimulus(1'b1, 100, 20, 20, 0);
`ifdef WIN_TIMEOUT_EN
        checkOutput("err_sticky", err_o, 1);
`else
        checkOutput("err_never", err_o, 0);
`endif

        valid_pct = 70; lat_min = 3; lat_max = 6; spur_pct = 0;
        pushFrame(1'b1);
        for (int n = 0; n < 3000 && !m_en; n++) @(negedge clk_i_win);
        checkOutput("en_before_reset", win_en_o, 1);
        @(posedge clk_i_win);
        #3 rst_i_win = 1'b1;
        #1 resetChecks("midrst");
        stream.delete();
        @(negedge clk_i_win);
        @(negedge clk_i_win);
        rst_i_win = 1'b0;

        applyStimulus(1'b1, 60, 2, 6, 20);
        applyStimulus(1'b1, 100, 2, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mean_window_feeder.md
Name: mean_window_feeder

Overview:
- Producer side of the 3x3 mean filter interface.
- Accepts a raster-order pixel stream and buffers two image lines in internal line buffers.
- Forms 3x3 windows (valid region only, no border padding) and presents them on nine parallel outputs with an enable level.
- Holds each window stable until the filter returns its done pulse. Output image size is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

Parameters:
- IMG_WIDTH, 8, pixels per line; must be >= 3.
- IMG_HEIGHT, 8, lines per frame; must be >= 3.
- DATA_WIDTH, 8, pixel width.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT_DONE; used only with WIN_TIMEOUT_EN.

Ports:
- clk_i_win  in  1  clock; all logic on rising edge.
- rst_i_win  in  1  asynchronous, active-high reset.
- pix_i  in  DATA_WIDTH  input pixel, raster order.
- pix_valid_i  in  1  pix_i valid.
- pix_ready_o  out  1  feeder can accept a pixel. A pixel transfers when pix_valid_i && pix_ready_o.
- win_o_0 .. win_o_8  out  DATA_WIDTH each  window, row-major. win_o_0 = (r-2,c-2), win_o_4 = centre (r-1,c-1), win_o_8 = (r,c).
- win_en_o  out  1  enable to filter; high while the window is presented.
- win_done_i  in  1  filter done pulse.
- frame_done_o  out  1  one-cycle pulse after the last window of a frame completes.
- err_o  out  1  sticky timeout flag; see Optional Feature.

Behaviour:
- Reset (async, rst_i_win=1):
  - Outputs: pix_ready_o=0, win_en_o=0, all win_o_*=0, frame_done_o=0, err_o=0.
  - Internals: col=0, row=0, state=FILL, timeout counter=0.
  - Line buffer contents are not cleared. Rows 0-1 are rewritten before any window uses them.
  - Reset mid-window drops win_en_o immediately; the in-flight window is discarded.
- Storage:
  - Two line buffers, lb_a (row r-2) and lb_b (row r-1), IMG_WIDTH x DATA_WIDTH each.
  - 3x3 window register array.
- On each accepted pixel p at (row,col):
  - Shift window columns left; new right column = {lb_a[col], lb_b[col], p}.
  - Write lb_a[col] <= lb_b[col] and lb_b[col] <= p.
  - Advance col. At IMG_WIDTH-1, wrap col to 0 and increment row. At (IMG_HEIGHT-1, IMG_WIDTH-1), wrap row and col to 0 and set a last-window flag.
- States:
  - FILL: pix_ready_o=1. On a transfer with row>=2 and col>=2, go to ISSUE next cycle; otherwise stay in FILL.
  - ISSUE (1 cycle): win_o_* driven from the window registers; win_en_o=1; pix_ready_o=0; go to WAIT_DONE.
  - WAIT_DONE: win_en_o=1; win_o_* held constant; pix_ready_o=0. When win_done_i=1 is sampled, go to GAP.
  - GAP (1 cycle): win_en_o=0 so the filter returns to its load state. If the last-window flag is set, pulse frame_done_o and clear the flag. Go to FILL.
- Latency: win_en_o rises 1 cycle after the transfer of the window-completing pixel.
- Steady state: one window per (filter latency + 3) cycles.
- win_done_i is ignored outside WAIT_DONE.
- pix_valid_i while pix_ready_o=0: the pixel is not consumed; the source must hold it.
- win_o_* change only in ISSUE and otherwise hold their value, including after win_en_o falls.
- Next frame starts immediately after GAP; no inter-frame gap is required.

Optional Feature:
- Macro: WIN_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT_CYCLES cycles elapse without win_done_i, set err_o=1 (sticky until reset), go to GAP, and skip that window.
  - The counter clears on entry to WAIT_DONE.
- Not defined: no counter; err_o tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset defaults: assert rst_i_win asynchronously mid-cycle -> all outputs 0 immediately. After release, pix_ready_o=1 next edge.
- First window (IMG_WIDTH=4, IMG_HEIGHT=4; pixels 0..15, valid always high; filter model returns done 5 cycles after en rises):
  - First win_en_o rises one cycle after pixel 10 transfers.
  - win_o_0..8 = 0,1,2,4,5,6,8,9,10.
- Full 4x4 frame (same setup):
  - Exactly 4 windows, in order: centres 5,6,9,10 (win_o_4).
  - Window 2 = 1,2,3,5,6,7,9,10,11.
  - frame_done_o pulses once, in the GAP after window 4.
  - Second frame 16..31 gives first window 16,17,18,20,21,22,24,25,26.
- Backpressure: pix_valid_i high during WAIT_DONE -> pix_ready_o=0, no pixel lost or duplicated, win_o_* constant throughout WAIT_DONE. win_done_i pulses in FILL are ignored.
- Stall source: pix_valid_i toggled randomly over a 4x4 frame -> windows identical to the continuous case.
- Timeout (WIN_TIMEOUT_EN, TIMEOUT_CYCLES=8): filter never returns done -> after 8 WAIT_DONE cycles err_o=1, win_en_o=0 for one cycle, pix_ready_o=1. Without the macro, win_en_o stays 1 and err_o=0.
